bram_dp_be: RTL and testbench
=============================

Name: bram_dp_be

Overview:
- Parametrised successor to the single-port block RAM. Provides one read/write port (A) with byte enables and a selectable read-during-write mode.
- Adds an independent read-only port (B), an optional output register stage, and per-port read-valid strobes.
- Has a built-in zeroization sequencer, used to wipe key/cookie buffers in the NTS engine without software looping.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 64, word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridable).
- OUTPUT_REG, 0, 0 = read latency 1, 1 = read latency 2 (extra output register on both ports).
- A_MODE, 0, port A read-during-write mode: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST.

Ports:
- i_clk  in  1  clock
- i_areset  in  1  asynchronous active-high reset
- i_clear  in  1  start zeroization sweep (pulse)
- o_busy  out  1  sweep in progress
- i_a_addr  in  ADDR_WIDTH  port A address
- i_a_read  in  1  port A read request
- i_a_write  in  1  port A write request
- i_a_be  in  BE_WIDTH  port A byte enables (bit n covers data[8n+7:8n])
- i_a_data  in  DATA_WIDTH  port A write data
- o_a_data  out  DATA_WIDTH  port A read data
- o_a_valid  out  1  o_a_data valid strobe
- i_b_addr  in  ADDR_WIDTH  port B address
- i_b_read  in  1  port B read request
- o_b_data  out  DATA_WIDTH  port B read data
- o_b_valid  out  1  o_b_data valid strobe

Behaviour:
- Reset: o_busy=0, o_a_data=0, o_a_valid=0, o_b_data=0, o_b_valid=0; sweep counter=0; FSM=IDLE. Memory array is not reset (must infer block RAM).
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when i_clear=1.
  - CLEAR writes all-zero to address cnt each cycle, cnt runs 0..DEPTH-1.
  - CLEAR -> IDLE on the cycle cnt=DEPTH-1 is written.
  - o_busy is registered: high for exactly DEPTH cycles starting the cycle after i_clear.
  - i_clear during CLEAR is ignored (no restart).
- While o_busy=1: port A writes are dropped; all read requests are dropped (valid strobes stay 0); o_*_data hold their last value.
- Port A write: on each rising edge with i_a_write=1, byte n of mem[i_a_addr] is updated iff i_a_be[n]=1. i_a_be=0 means no change. Other bytes are preserved.
- Port A read (i_a_read=1, i_a_write=0): mem[i_a_addr] is returned.
- Port A with i_a_read=1 and i_a_write=1 in the same cycle behaves per A_MODE:
  - NO_CHANGE: o_a_data holds its previous value; o_a_valid=0.
  - READ_FIRST: returns the pre-write word; o_a_valid=1.
  - WRITE_FIRST: returns the merged post-write word; o_a_valid=1.
- i_a_write=1 with i_a_read=0 never updates o_a_data or asserts o_a_valid.
- Port B read: returns mem[i_b_addr]. If port A writes the same address in the same cycle, B returns the old word (read-first), in all modes.
- Latency:
  - OUTPUT_REG=0: data and valid appear on the edge after the request (1 cycle).
  - OUTPUT_REG=1: 2 cycles.
  - Valid is a one-cycle strobe per request; back-to-back requests yield back-to-back strobes, full throughput.
  - Data outputs hold between strobes.
- In the OUTPUT_REG=1 pipeline, a request accepted before o_busy rises still completes (its strobe may appear during the first busy cycle).
- Address wrap: none needed; any ADDR_WIDTH value is valid. The last address is DEPTH-1.
- Reset mid-sweep: the sweep aborts immediately, o_busy=0, and memory is left partially cleared. A new i_clear restarts from address 0.

Test Plan:
- Byte-enable write (DATA_WIDTH=64): write 0x1122334455667788 to addr 5 with be=0xFF, then write 0xAAAAAAAAAAAAAAAA with be=0x0F, then read addr 5 -> 0x11223344AAAAAAAA, o_a_valid high exactly 1 cycle (2 with OUTPUT_REG=1).
- Read-during-write on port A, addr 3 preloaded 0x01, write 0x02 with read=1: NO_CHANGE -> o_a_valid=0 and o_a_data unchanged; READ_FIRST -> 0x01; WRITE_FIRST -> 0x02.
- Port collision: A writes 0xBEEF to addr 9 (old 0x1234) while B reads addr 9 in the same cycle -> o_b_data=0x1234; B re-reads the next cycle -> 0xBEEF.
- Clear sweep (ADDR_WIDTH=4): fill all 16 words with nonzero values, pulse i_clear -> o_busy high exactly 16 cycles. A write and reads issued during busy are dropped with no valid strobes. Afterwards every address reads 0.
- Reset mid-sweep (ADDR_WIDTH=4): assert i_areset after 6 busy cycles -> all outputs 0 asynchronously; addresses 0..5 read 0 and addresses 6..15 keep their prior values. A new i_clear completes a full 16-cycle sweep.
- Streaming on port B with OUTPUT_REG=1: read addresses 0..7 on consecutive cycles -> 8 consecutive valid strobes starting 2 cycles after the first request, data in address order.

Source files
------------

// File: rtl/bram_dp_be.sv
// rtl/bram_dp_be.sv - dual-port block RAM with byte enables, read-only port B and zeroization sweep
//
// Ports:
//   i_clk, i_areset           clock, asynchronous active-high reset
//   i_clear / o_busy          start zeroization sweep / sweep in progress
//   i_a_addr, i_a_read,       port A: read/write with byte enables
//   i_a_write, i_a_be,        (i_a_be bit n covers data[8n+7:8n])
//   i_a_data, o_a_data,
//   o_a_valid
//   i_b_addr, i_b_read,       port B: read only, read-first against port A writes
//   o_b_data, o_b_valid
module bram_dp_be #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int OUTPUT_REG = 0,
    parameter int A_MODE     = 0
) (
    input  logic                      i_clk,
    input  logic                      i_areset,
    input  logic                      i_clear,
    output logic                      o_busy,
    input  logic [ADDR_WIDTH-1:0]     i_a_addr,
    input  logic                      i_a_read,
    input  logic                      i_a_write,
    input  logic [DATA_WIDTH/8-1:0]   i_a_be,
    input  logic [DATA_WIDTH-1:0]     i_a_data,
    output logic [DATA_WIDTH-1:0]     o_a_data,
    output logic                      o_a_valid,
    input  logic [ADDR_WIDTH-1:0]     i_b_addr,
    input  logic                      i_b_read,
    output logic [DATA_WIDTH-1:0]     o_b_data,
    output logic                      o_b_valid
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic { IDLE, CLEAR } state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nx;
    logic                    sweep;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sweep    = 1'b0;
        case (state)
            IDLE: begin
                if (i_clear) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                sweep  = 1'b1;
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Busy comes straight from the state register, so it is glitch-free.
    assign o_busy = (state == CLEAR);

    // In NO_CHANGE mode a simultaneous read+write is not a read at all.
    logic a_wr, a_rd, b_rd;
    assign a_wr = i_a_write & ~o_busy;
    assign a_rd = i_a_read & ~o_busy & (~i_a_write | (A_MODE != 0));
    assign b_rd = i_b_read & ~o_busy;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a_raw, b_raw, a_merge;

    // Post-write view of the port A word, used only for WRITE_FIRST reads.
    always_comb begin
        a_merge = mem[i_a_addr];
        for (int n = 0; n < BE_WIDTH; n++) begin
            if (i_a_be[n]) begin
                a_merge[8*n +: 8] = i_a_data[8*n +: 8];
            end
        end
    end

    // No reset on the array or raw read registers so the array maps to block RAM.
    always_ff @(posedge i_clk) begin
        if (sweep) begin
            mem[cnt] <= '0;
        end else if (a_wr) begin
            for (int n = 0; n < BE_WIDTH; n++) begin
                if (i_a_be[n]) begin
                    mem[i_a_addr][8*n +: 8] <= i_a_data[8*n +: 8];
                end
            end
        end
        if (a_rd) begin
            a_raw <= ((A_MODE == 2) && i_a_write) ? a_merge : mem[i_a_addr];
        end
        if (b_rd) begin
            b_raw <= mem[i_b_addr];
        end
    end

    logic a_v1, b_v1;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
        end else begin
            a_v1 <= a_rd;
            b_v1 <= b_rd;
        end
    end

    generate
        if (OUTPUT_REG == 0) begin : g_direct
            // The raw registers cannot be reset, so mask them to zero until
            // the first read after reset has loaded them.
            logic a_seen, b_seen;
            always_ff @(posedge i_clk or posedge i_areset) begin
                if (i_areset) begin
                    a_seen <= 1'b0;
                    b_seen <= 1'b0;
                end else begin
                    a_seen <= a_seen | a_rd;
                    b_seen <= b_seen | b_rd;
                end
            end
            assign o_a_data  = a_seen ? a_raw : '0;
            assign o_b_data  = b_seen ? b_raw : '0;
            assign o_a_valid = a_v1;
            assign o_b_valid = b_v1;
        end else begin : g_outreg
            // Stage 2 ignores busy so a read accepted just before a sweep completes.
            always_ff @(posedge i_clk or posedge i_areset) begin
                if (i_areset) begin
                    o_a_data  <= '0;
                    o_b_data  <= '0;
                    o_a_valid <= 1'b0;
                    o_b_valid <= 1'b0;
                end else begin
                    if (a_v1) o_a_data <= a_raw;
                    if (b_v1) o_b_data <= b_raw;
                    o_a_valid <= a_v1;
                    o_b_valid <= b_v1;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_bram_dp_be.sv
// tb/tb_bram_dp_be.sv - testbench for bram_dp_be (three configurations on shared stimulus)
module tb_bram_dp_be;
    logic        clk, rst, clr;
    logic [3:0]  a_addr, b_addr;
    logic        a_read, a_write, b_read;
    logic [7:0]  a_be;
    logic [63:0] a_data;

    logic [2:0]       busy, a_v, b_v;
    logic [2:0][63:0] a_d, b_d;

    int nchk = 0;
    int nerr = 0;
    bit cmp_en = 0;

    // Instance 0: latency 1, NO_CHANGE; 1: latency 1, READ_FIRST; 2: latency 2, WRITE_FIRST
    bram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .OUTPUT_REG(0), .A_MODE(0)) u0 (
        .i_clk(clk), .i_areset(rst), .i_clear(clr), .o_busy(busy[0]),
        .i_a_addr(a_addr), .i_a_read(a_read), .i_a_write(a_write), .i_a_be(a_be),
        .i_a_data(a_data), .o_a_data(a_d[0]), .o_a_valid(a_v[0]),
        .i_b_addr(b_addr), .i_b_read(b_read), .o_b_data(b_d[0]), .o_b_valid(b_v[0]));
    bram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .OUTPUT_REG(0), .A_MODE(1)) u1 (
        .i_clk(clk), .i_areset(rst), .i_clear(clr), .o_busy(busy[1]),
        .i_a_addr(a_addr), .i_a_read(a_read), .i_a_write(a_write), .i_a_be(a_be),
        .i_a_data(a_data), .o_a_data(a_d[1]), .o_a_valid(a_v[1]),
        .i_b_addr(b_addr), .i_b_read(b_read), .o_b_data(b_d[1]), .o_b_valid(b_v[1]));
    bram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .OUTPUT_REG(1), .A_MODE(2)) u2 (
        .i_clk(clk), .i_areset(rst), .i_clear(clr), .o_busy(busy[2]),
        .i_a_addr(a_addr), .i_a_read(a_read), .i_a_write(a_write), .i_a_be(a_be),
        .i_a_data(a_data), .o_a_data(a_d[2]), .o_a_valid(a_v[2]),
        .i_b_addr(b_addr), .i_b_read(b_read), .o_b_data(b_d[2]), .o_b_valid(b_v[2]));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: memory contents, sweep progress and expected outputs.
    logic [63:0] m_mem [16];
    logic        m_busy;
    logic [3:0]  m_cnt;
    logic        e_busy;
    logic        e_av [3], e_bv [3], s_av [3], s_bv [3];
    logic [63:0] e_ad [3], e_bd [3], s_ad [3], s_bd [3];
    logic [63:0] m_old, m_mrg, r_ad, r_bd;
    logic        r_av, r_bv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_cnt = 0; e_busy = 0;
            for (int i = 0; i < 3; i++) begin
                e_av[i] = 0; e_bv[i] = 0; e_ad[i] = 0; e_bd[i] = 0;
                s_av[i] = 0; s_bv[i] = 0; s_ad[i] = 0; s_bd[i] = 0;
            end
        end else begin
            m_old = m_mem[a_addr];
            m_mrg = m_old;
            for (int n = 0; n < 8; n++)
                if (a_be[n]) m_mrg[8*n +: 8] = a_data[8*n +: 8];
            for (int i = 0; i < 3; i++) begin
                r_av = 0; r_ad = 0;
                if (!m_busy && a_read) begin
                    if (!a_write)    begin r_av = 1; r_ad = m_old; end
                    else if (i == 1) begin r_av = 1; r_ad = m_old; end
                    else if (i == 2) begin r_av = 1; r_ad = m_mrg; end
                end
                r_bv = !m_busy && b_read;
                r_bd = m_mem[b_addr];
                if (i == 2) begin
                    e_av[i] = s_av[i]; if (s_av[i]) e_ad[i] = s_ad[i];
                    e_bv[i] = s_bv[i]; if (s_bv[i]) e_bd[i] = s_bd[i];
                    s_av[i] = r_av; s_ad[i] = r_ad;
                    s_bv[i] = r_bv; s_bd[i] = r_bd;
                end else begin
                    e_av[i] = r_av; if (r_av) e_ad[i] = r_ad;
                    e_bv[i] = r_bv; if (r_bv) e_bd[i] = r_bd;
                end
            end
            if (m_busy) begin
                m_mem[m_cnt] = 0;
                if (m_cnt == 15) m_busy = 0;
                m_cnt = m_cnt + 1;
            end else begin
                if (a_write) m_mem[a_addr] = m_mrg;
                if (clr) begin m_busy = 1; m_cnt = 0; end
            end
            e_busy = m_busy;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy%0d", i),   busy[i], e_busy);
                chk($sformatf("a_valid%0d", i), a_v[i], e_av[i]);
                chk($sformatf("b_valid%0d", i), b_v[i], e_bv[i]);
                chk($sformatf("a_data%0d", i),  a_d[i], e_ad[i]);
                chk($sformatf("b_data%0d", i),  b_d[i], e_bd[i]);
            end
        end
    end

    function automatic logic [63:0] fv(input int a, input int salt);
        return {16'hC0DE, 16'(salt), 16'hF00D, 16'(a + 1)};
    endfunction

    task automatic op(input logic [3:0] aa, input logic ar, input logic aw, input logic [7:0] be,
                      input logic [63:0] ad, input logic [3:0] ba, input logic br);
        a_addr = aa; a_read = ar; a_write = aw; a_be = be; a_data = ad;
        b_addr = ba; b_read = br;
        @(negedge clk);
        a_read = 0; a_write = 0; b_read = 0; clr = 0;
    endtask

    task automatic fill(input int salt);
        for (int a = 0; a < 16; a++) op(4'(a), 0, 1, 8'hFF, fv(a, salt), 0, 0);
    endtask

    task automatic count_busy(input string nm, input bit disturb);
        int n = 0;
        while (busy[0] === 1'b1 && n < 40) begin
            if (disturb && n == 2) begin
                a_addr = 7; a_read = 1; a_write = 1; a_be = 8'hFF; a_data = 64'hFFFF;
                b_addr = 7; b_read = 1;
            end
            if (disturb && n == 5) clr = 1;
            @(negedge clk);
            a_read = 0; a_write = 0; b_read = 0; clr = 0;
            n++;
        end
        chk(nm, 64'(n), 64'd16);
    endtask

    logic        sv [10];
    logic [63:0] sd [10];

    initial begin
        rst = 0; clr = 0; a_addr = 0; b_addr = 0; a_read = 0; a_write = 0; b_read = 0;
        a_be = 0; a_data = 0;
        cmp_en = 1;
        #1 rst = 1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_a_data%0d", i), a_d[i], 0);
            chk($sformatf("rst_b_valid%0d", i), b_v[i], 0);
        end
        rst = 0;
        @(negedge clk);
        fill(1);

        // byte enables
        op(5, 0, 1, 8'hFF, 64'h1122334455667788, 0, 0);
        op(5, 0, 1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0);
        op(5, 1, 0, 8'h00, 64'h0, 0, 0);
        chk("be_data_l1", a_d[0], 64'h11223344AAAAAAAA);
        chk("be_valid_l1", a_v[0], 1);
        chk("be_valid_l2_early", a_v[2], 0);
        @(negedge clk);
        chk("be_valid_l1_off", a_v[0], 0);
        chk("be_data_l2", a_d[2], 64'h11223344AAAAAAAA);
        chk("be_valid_l2", a_v[2], 1);
        @(negedge clk);
        chk("be_valid_l2_off", a_v[2], 0);

        // read during write on port A
        op(3, 0, 1, 8'hFF, 64'h1, 0, 0);
        op(3, 1, 1, 8'hFF, 64'h2, 0, 0);
        chk("nochange_valid", a_v[0], 0);
        chk("nochange_hold", a_d[0], 64'h11223344AAAAAAAA);
        chk("readfirst_data", a_d[1], 64'h1);
        chk("readfirst_valid", a_v[1], 1);
        @(negedge clk);
        chk("writefirst_data", a_d[2], 64'h2);
        chk("writefirst_valid", a_v[2], 1);

        // port collision
        op(9, 0, 1, 8'hFF, 64'h1234, 0, 0);
        op(9, 0, 1, 8'hFF, 64'hBEEF, 9, 1);
        chk("collide_old", b_d[0], 64'h1234);
        chk("collide_valid", b_v[0], 1);
        op(0, 0, 0, 8'h00, 64'h0, 9, 1);
        chk("collide_new", b_d[0], 64'hBEEF);
        @(negedge clk);

        // streaming on port B, latency 2
        for (int a = 0; a < 8; a++) op(4'(a), 0, 1, 8'hFF, fv(a, 2), 0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            if (j < 8) op(0, 0, 0, 8'h00, 64'h0, 4'(j), 1);
            else @(negedge clk);
            sv[j] = b_v[2];
            sd[j] = b_d[2];
        end
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("stream_valid%0d", j), sv[j], (j >= 1 && j <= 8));
            if (j >= 1 && j <= 8) chk($sformatf("stream_data%0d", j), sd[j], fv(j - 1, 2));
        end

        // clear sweep with dropped accesses and an ignored second clear
        fill(3);
        clr = 1;
        op(0, 0, 0, 8'h00, 64'h0, 0, 0);
        count_busy("sweep_len", 1);
        for (int a = 0; a < 16; a++) begin
            op(4'(a), 1, 0, 8'h00, 64'h0, 4'(a), 1);
            chk($sformatf("swept_a%0d", a), a_d[0], 0);
            chk($sformatf("swept_b%0d", a), b_d[0], 0);
        end

        // reset in the middle of a sweep
        fill(4);
        op(15, 1, 0, 8'h00, 64'h0, 15, 1);
        @(negedge clk);
        clr = 1;
        op(0, 0, 0, 8'h00, 64'h0, 0, 0);
        repeat (6) @(negedge clk);
        #2 rst = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid_busy%0d", i), busy[i], 0);
            chk($sformatf("mid_a_data%0d", i), a_d[i], 0);
            chk($sformatf("mid_b_data%0d", i), b_d[i], 0);
        end
        @(negedge clk);
        rst = 0;
        for (int a = 0; a < 16; a++) begin
            op(4'(a), 1, 0, 8'h00, 64'h0, 4'(a), 1);
            chk($sformatf("partial_a%0d", a), a_d[0], (a < 6) ? 64'h0 : fv(a, 4));
            chk($sformatf("partial_b%0d", a), b_d[1], (a < 6) ? 64'h0 : fv(a, 4));
        end
        clr = 1;
        op(0, 0, 0, 8'h00, 64'h0, 0, 0);
        count_busy("resweep_len", 0);

        // randomized traffic
        fill(5);
        for (int k = 0; k < 600; k++) begin
            a_addr = 4'($urandom_range(0, 15));
            a_read = 1'($urandom_range(0, 1));
            a_write = 1'($urandom_range(0, 1));
            a_be = 8'($urandom);
            a_data = {$urandom, $urandom};
            b_addr = 4'($urandom_range(0, 15));
            b_read = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        a_read = 0; a_write = 0; b_read = 0; clr = 0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
